mc_ctrl_hs: RTL and testbench

Multicycle MIPS control FSM, next generation of the core controller. Decodes op/funct and sequences IF/ID/EX/MEM/WB. Adds a memory ready handshake with wait states, more instructions (andi/ori/xori/slti/lui/jr/jal), an illegal-opcode trap, and a parametrised state and ALU-op width. Sits between the instruction register and the datapath muxes and enables.

---
 rtl/mc_ctrl_hs.sv | 250 +++++++++++++++++++++++++
 tb/tb_mc_ctrl_hs.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_hs.sv
// Multicycle MIPS control FSM with memory-ready handshake, extended ISA and illegal-opcode trap.
// Build option MC_MEM_TIMEOUT_EN adds a bounded wait on mem_ready that traps on expiry.
module mc_ctrl_hs #(
  parameter int OP_W        = 6,
  parameter int STATE_W     = 5,
  parameter int ALUOP_W     = 3,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    op,
  input  logic [OP_W-1:0]    funct,
  input  logic               mem_ready,
  output logic [STATE_W-1:0] state,
  output logic [1:0]         reg_dst,
  output logic               reg_write,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               imm_zext,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               iord,
  output logic               ir_write,
  output logic               mem_read,
  output logic               mem_write,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               pc_cond_ne,
  output logic [1:0]         pc_source,
  output logic               trap
);

  if (STATE_W < 5) begin : g_bad_state_w
    $error("mc_ctrl_hs: STATE_W must be at least 5");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mc_ctrl_hs: TIMEOUT_CYC must be at least 1");
  end

  localparam logic [STATE_W-1:0] S_IF     = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_ID     = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_EX_MA  = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_RD = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_WB_LD  = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEM_WR = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EX_R   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_WB_R   = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_EX_I   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_WB_I   = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_BR_EQ  = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_BR_NE  = STATE_W'(11);
  localparam logic [STATE_W-1:0] S_JAL_L  = STATE_W'(12);
  localparam logic [STATE_W-1:0] S_JMP    = STATE_W'(13);
  localparam logic [STATE_W-1:0] S_JR     = STATE_W'(14);
  localparam logic [STATE_W-1:0] S_TRAP   = STATE_W'(15);
  localparam logic [STATE_W-1:0] S_RST    = {STATE_W{1'b1}};

  localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_JAL   = OP_W'(6'b000011);
  localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
  localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
  localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(6'b001010);
  localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(6'b001100);
  localparam logic [OP_W-1:0] OP_ORI   = OP_W'(6'b001101);
  localparam logic [OP_W-1:0] OP_XORI  = OP_W'(6'b001110);
  localparam logic [OP_W-1:0] OP_LUI   = OP_W'(6'b001111);
  localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] FN_JR    = OP_W'(6'b001000);

  localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'd0);
  localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(3'd1);
  localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(3'd2);
  localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'd3);
  localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'd4);
  localparam logic [ALUOP_W-1:0] ALU_XOR = ALUOP_W'(3'd5);
  localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(3'd6);
  localparam logic [ALUOP_W-1:0] ALU_LUI = ALUOP_W'(3'd7);

  logic [STATE_W-1:0] state_q, state_d;
  logic               trap_q, trap_d;
  logic               waiting;

  // States that stall on the memory handshake.
  assign waiting = (state_q == S_IF) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);

`ifdef MC_MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             timeout;
  assign timeout = waiting && !mem_ready && (wait_q == CNT_W'(TIMEOUT_CYC));
`else
  logic timeout;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:    state_d = S_IF;
      S_IF:     if (mem_ready) state_d = S_ID;
      S_ID: begin
        case (op)
          OP_RTYPE:                 state_d = (funct == FN_JR) ? S_JR : S_EX_R;
          OP_LW, OP_SW:             state_d = S_EX_MA;
          OP_ADDI, OP_SLTI, OP_LUI,
          OP_ANDI, OP_ORI, OP_XORI: state_d = S_EX_I;
          OP_BEQ:                   state_d = S_BR_EQ;
          OP_BNE:                   state_d = S_BR_NE;
          OP_J:                     state_d = S_JMP;
          OP_JAL:                   state_d = S_JAL_L;
          default:                  state_d = S_TRAP;
        endcase
      end
      S_EX_MA:  state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_LD;
      S_WB_LD:  state_d = S_IF;
      S_MEM_WR: if (mem_ready) state_d = S_IF;
      S_EX_R:   state_d = S_WB_R;
      S_WB_R:   state_d = S_IF;
      S_EX_I:   state_d = S_WB_I;
      S_WB_I:   state_d = S_IF;
      S_BR_EQ,
      S_BR_NE:  state_d = S_IF;
      S_JAL_L:  state_d = S_JMP;
      S_JMP:    state_d = S_IF;
      S_JR:     state_d = S_IF;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_IF;
    endcase
    if (timeout) state_d = S_TRAP;
  end

  assign trap_d = trap_q || (state_d == S_TRAP);

`ifdef MC_MEM_TIMEOUT_EN
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)        wait_d = '0;
    else if (waiting && !mem_ready) wait_d = wait_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

  assign state = state_q;
  assign trap  = trap_q;

  // Moore decode; only the IF fetch strobes look at mem_ready.
  always_comb begin
    reg_dst       = 2'b00;
    reg_write     = 1'b0;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_zext      = 1'b0;
    alu_op        = ALU_ADD;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_cond_ne    = 1'b0;
    pc_source     = 2'b00;
    case (state_q)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_ID:     alu_src_b = 2'b11;
      S_EX_MA: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_WB_LD: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FN;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (op)
          OP_ANDI: begin alu_op = ALU_AND; imm_zext = 1'b1; end
          OP_ORI:  begin alu_op = ALU_OR;  imm_zext = 1'b1; end
          OP_XORI: begin alu_op = ALU_XOR; imm_zext = 1'b1; end
          OP_SLTI: alu_op = ALU_SLT;
          OP_LUI:  alu_op = ALU_LUI;
          default: alu_op = ALU_ADD;
        endcase
      end
      S_WB_I:   reg_write = 1'b1;
      S_BR_EQ, S_BR_NE: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        pc_cond_ne    = (state_q == S_BR_NE);
      end
      S_JAL_L: begin
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
      end
      S_JMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl_hs.sv
// Table-driven bench for mc_ctrl_hs: per-cycle {inputs, expected state/controls} rows
// checked through a scoreboard queue, plus hand sequences for reset abort and memory timeout.
module tb_mc_ctrl_hs;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] op = '0, funct = '0;
  logic       mem_ready = 1'b0;
  logic [4:0] state;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_source;
  logic       reg_write, alu_src_a, imm_zext, iord, ir_write, mem_read, mem_write;
  logic       pc_write, pc_write_cond, pc_cond_ne, trap;
  logic [2:0] alu_op;

  mc_ctrl_hs dut (
    .clk(clk), .rst(rst), .op(op), .funct(funct), .mem_ready(mem_ready), .state(state),
    .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .imm_zext(imm_zext), .alu_op(alu_op), .iord(iord),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .pc_cond_ne(pc_cond_ne), .pc_source(pc_source), .trap(trap)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] S_IF = 0, S_ID = 1, S_EX_MA = 2, S_MEM_RD = 3, S_WB_LD = 4,
                         S_MEM_WR = 5, S_EX_R = 6, S_WB_R = 7, S_EX_I = 8, S_WB_I = 9,
                         S_BR_EQ = 10, S_BR_NE = 11, S_JAL_L = 12, S_JMP = 13, S_JR = 14,
                         S_TRAP = 15, S_RST = 5'b11111;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        rdy;
    logic [4:0]  st;
    logic [21:0] cw;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   total = 0, bad = 0;

  wire [21:0] dut_cw = {reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, imm_zext, alu_op,
                        iord, ir_write, mem_read, mem_write, pc_write, pc_write_cond,
                        pc_cond_ne, pc_source, trap};

  function automatic logic [21:0] mk(input logic [1:0] rd, input logic rw, input logic [1:0] m2r,
                                     input logic a, input logic [1:0] b, input logic zx,
                                     input logic [2:0] ao, input logic io, input logic irw,
                                     input logic mr, input logic mw, input logic pcw,
                                     input logic pcc, input logic ne, input logic [1:0] ps,
                                     input logic tr);
    return {rd, rw, m2r, a, b, zx, ao, io, irw, mr, mw, pcw, pcc, ne, ps, tr};
  endfunction

  logic [21:0] C_IF1, C_IF0, C_ID, C_EXMA, C_MEMRD, C_WBLD, C_MEMWR, C_EXR, C_WBR, C_WBI;
  logic [21:0] C_ADDI, C_ANDI, C_ORI, C_XORI, C_SLTI, C_LUI, C_BEQ, C_BNE, C_JAL, C_JMP, C_JR;
  logic [21:0] C_TRAP;

  task automatic add(input logic [5:0] o, input logic [5:0] f, input logic r,
                     input logic [4:0] s, input logic [21:0] c);
    vec_t v;
    v.op = o; v.funct = f; v.rdy = r; v.st = s; v.cw = c;
    vecs.push_back(v);
  endtask

  // Fetch with ready, then decode of the given instruction.
  task automatic fetch_dec(input logic [5:0] o, input logic [5:0] f);
    add(o, f, 1'b1, S_IF, C_IF1);
    add(o, f, 1'b1, S_ID, C_ID);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic cyc(input logic [5:0] o, input logic [5:0] f, input logic r);
    @(negedge clk);
    op = o; funct = f; mem_ready = r;
  endtask

  initial begin
    int n;
    vec_t e;
    C_IF1   = mk(0,0,0, 0,1,0,0, 0,1,1,0,1,0,0,0, 0);
    C_IF0   = mk(0,0,0, 0,1,0,0, 0,0,1,0,0,0,0,0, 0);
    C_ID    = mk(0,0,0, 0,3,0,0, 0,0,0,0,0,0,0,0, 0);
    C_EXMA  = mk(0,0,0, 1,2,0,0, 0,0,0,0,0,0,0,0, 0);
    C_MEMRD = mk(0,0,0, 0,0,0,0, 1,0,1,0,0,0,0,0, 0);
    C_WBLD  = mk(0,1,1, 0,0,0,0, 0,0,0,0,0,0,0,0, 0);
    C_MEMWR = mk(0,0,0, 0,0,0,0, 1,0,0,1,0,0,0,0, 0);
    C_EXR   = mk(0,0,0, 1,0,0,2, 0,0,0,0,0,0,0,0, 0);
    C_WBR   = mk(1,1,0, 0,0,0,0, 0,0,0,0,0,0,0,0, 0);
    C_WBI   = mk(0,1,0, 0,0,0,0, 0,0,0,0,0,0,0,0, 0);
    C_ADDI  = mk(0,0,0, 1,2,0,0, 0,0,0,0,0,0,0,0, 0);
    C_ANDI  = mk(0,0,0, 1,2,1,3, 0,0,0,0,0,0,0,0, 0);
    C_ORI   = mk(0,0,0, 1,2,1,4, 0,0,0,0,0,0,0,0, 0);
    C_XORI  = mk(0,0,0, 1,2,1,5, 0,0,0,0,0,0,0,0, 0);
    C_SLTI  = mk(0,0,0, 1,2,0,6, 0,0,0,0,0,0,0,0, 0);
    C_LUI   = mk(0,0,0, 1,2,0,7, 0,0,0,0,0,0,0,0, 0);
    C_BEQ   = mk(0,0,0, 1,0,0,1, 0,0,0,0,0,1,0,1, 0);
    C_BNE   = mk(0,0,0, 1,0,0,1, 0,0,0,0,0,1,1,1, 0);
    C_JAL   = mk(2,1,2, 0,0,0,0, 0,0,0,0,0,0,0,0, 0);
    C_JMP   = mk(0,0,0, 0,0,0,0, 0,0,0,0,1,0,0,2, 0);
    C_JR    = mk(0,0,0, 0,0,0,0, 0,0,0,0,1,0,0,3, 0);
    C_TRAP  = mk(0,0,0, 0,0,0,0, 0,0,0,0,0,0,0,0, 1);

    add(6'h08, 0, 1, S_RST, 22'd0);
    fetch_dec(6'h08, 0); add(6'h08, 0, 1, S_EX_I, C_ADDI); add(6'h08, 0, 1, S_WB_I, C_WBI);
    fetch_dec(6'h23, 0); add(6'h23, 0, 0, S_EX_MA, C_EXMA);
    for (int i = 0; i < 3; i++) add(6'h23, 0, 0, S_MEM_RD, C_MEMRD);
    add(6'h23, 0, 1, S_MEM_RD, C_MEMRD); add(6'h23, 0, 1, S_WB_LD, C_WBLD);
    add(6'h2b, 0, 0, S_IF, C_IF0); add(6'h2b, 0, 0, S_IF, C_IF0);
    fetch_dec(6'h2b, 0); add(6'h2b, 0, 1, S_EX_MA, C_EXMA);
    add(6'h2b, 0, 0, S_MEM_WR, C_MEMWR); add(6'h2b, 0, 0, S_MEM_WR, C_MEMWR);
    add(6'h2b, 0, 1, S_MEM_WR, C_MEMWR);
    fetch_dec(6'h00, 6'h20); add(0, 6'h20, 1, S_EX_R, C_EXR); add(0, 6'h20, 1, S_WB_R, C_WBR);
    fetch_dec(6'h00, 6'h08); add(0, 6'h08, 1, S_JR, C_JR);
    fetch_dec(6'h03, 0); add(6'h03, 0, 1, S_JAL_L, C_JAL); add(6'h03, 0, 1, S_JMP, C_JMP);
    fetch_dec(6'h02, 0); add(6'h02, 0, 1, S_JMP, C_JMP);
    fetch_dec(6'h04, 0); add(6'h04, 0, 1, S_BR_EQ, C_BEQ);
    fetch_dec(6'h05, 0); add(6'h05, 0, 1, S_BR_NE, C_BNE);
    fetch_dec(6'h0c, 0); add(6'h0c, 0, 1, S_EX_I, C_ANDI); add(6'h0c, 0, 1, S_WB_I, C_WBI);
    fetch_dec(6'h0d, 0); add(6'h0d, 0, 1, S_EX_I, C_ORI);  add(6'h0d, 0, 1, S_WB_I, C_WBI);
    fetch_dec(6'h0e, 0); add(6'h0e, 0, 1, S_EX_I, C_XORI); add(6'h0e, 0, 1, S_WB_I, C_WBI);
    fetch_dec(6'h0a, 0); add(6'h0a, 0, 1, S_EX_I, C_SLTI); add(6'h0a, 0, 1, S_WB_I, C_WBI);
    fetch_dec(6'h0f, 0); add(6'h0f, 0, 1, S_EX_I, C_LUI);  add(6'h0f, 0, 1, S_WB_I, C_WBI);
    fetch_dec(6'h3f, 0);
    for (int i = 0; i < 20; i++) add(6'h3f, 0, i[0], S_TRAP, C_TRAP);

    // Reset state while rst is held.
    repeat (2) @(negedge clk);
    #1;
    chk("reset_state", 32'(state), 32'(S_RST));
    chk("reset_ctrl", 32'(dut_cw), 32'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      op = vecs[i].op; funct = vecs[i].funct; mem_ready = vecs[i].rdy;
      exp_q.push_back(vecs[i]);
      #1;
      e = exp_q.pop_front();
      total++;
      if (state !== e.st || dut_cw !== e.cw || (mem_read && mem_write)) begin
        bad++;
        $display("FAIL row%0d: state=%0d ctrl=%h, expected state=%0d ctrl=%h",
                 i, state, dut_cw, e.st, e.cw);
      end
    end

    // rst during trap returns to RST_S with trap cleared.
    @(negedge clk); #2 rst = 1'b1; #1;
    chk("trap_rst_state", 32'(state), 32'(S_RST));
    chk("trap_rst_ctrl", 32'(dut_cw), 32'd0);

    // rst mid memory wait aborts at once, with no request left asserted.
    @(negedge clk); rst = 1'b0;
    cyc(6'h23, 0, 1); cyc(6'h23, 0, 1); cyc(6'h23, 0, 0); cyc(6'h23, 0, 0); #1;
    chk("lw_wait_state", 32'(state), 32'(S_MEM_RD));
    chk("lw_wait_read", 32'(mem_read), 32'd1);
    #2 rst = 1'b1; #1;
    chk("abort_state", 32'(state), 32'(S_RST));
    chk("abort_ctrl", 32'(dut_cw), 32'd0);
    @(negedge clk); #1;
    chk("abort_hold", 32'(state), 32'(S_RST));

    // Fetch never acknowledged.
    @(negedge clk); rst = 1'b0; op = 0; funct = 0; mem_ready = 1'b0;
    @(negedge clk);
    n = 0;
`ifdef MC_MEM_TIMEOUT_EN
    for (int i = 0; i < 40 && state != S_TRAP; i++) begin
      @(negedge clk);
      n++;
    end
    #1;
    chk("timeout_state", 32'(state), 32'(S_TRAP));
    chk("timeout_trap", 32'(trap), 32'd1);
    total++;
    if (n < 15 || n > 16) begin
      bad++;
      $display("FAIL timeout_cycles: got %0d wait cycles, expected 15..16", n);
    end
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (state == S_IF && mem_read && !ir_write && !trap) n++;
    end
    #1;
    chk("no_timeout_state", 32'(state), 32'(S_IF));
    chk("no_timeout_cycles", 32'(n), 32'd100);
    chk("no_timeout_trap", 32'(trap), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
